// File: rtl/bin_sevenseg_scan.sv
// Binary to BCD converter (sequential double-dabble) driving a multiplexed active-low 7-segment display.
// Optional leading-zero blanking is enabled by defining SEVSEG_LZ_BLANK_EN.
module bin_sevenseg_scan #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WIDTH-1:0]  value,
  output logic              busy,
  output logic              ready,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int BCDW = 4 * DIGITS;
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // True when DIGITS decimal digits can hold every WIDTH-bit unsigned value.
  function automatic bit digitsFit(input int w, input int d);
    logic [255:0] pow10;
    pow10 = 256'd1;
    for (int i = 0; i < d; i++) pow10 = pow10 * 256'd10;
    return pow10 >= (256'd1 << w);
  endfunction

  if (!digitsFit(WIDTH, DIGITS)) begin : g_badDigits
    $error("bin_sevenseg_scan: DIGITS too small for WIDTH");
  end
  if (SCAN_DIV < 1) begin : g_badScanDiv
    $error("bin_sevenseg_scan: SCAN_DIV must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BCDW-1:0]   bcd_q, bcd_d;
  logic [BCDW-1:0]   bcdAdj;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [BCDW-1:0]   disp_q, disp_d;
  logic [DIVW-1:0]   div_q, div_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [DIGITS-1:0] blank;
  logic [3:0]        digSel;

  function automatic logic [6:0] segEncode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0001100;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    bcdAdj  = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcdAdj[4*k +: 4] >= 4'd5) bcdAdj[4*k +: 4] = bcdAdj[4*k +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (load) begin
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcdAdj, bin_q} << 1;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        disp_d  = bcd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan position advances once per SCAN_DIV clocks, free-running regardless of conversion state.
  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    if (div_q == DIVW'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDXW'(DIGITS - 1)) ? '0 : idx_q + IDXW'(1);
    end else begin
      div_d = div_q + DIVW'(1);
    end
  end

`ifdef SEVSEG_LZ_BLANK_EN
  logic zeroRun;
  always_comb begin
    blank   = '0;
    zeroRun = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zeroRun  = zeroRun && (disp_d[4*k +: 4] == 4'd0);
      blank[k] = zeroRun;
    end
  end
`else
  assign blank = '0;
`endif

  // Segment pattern and anode select come from the next-cycle index and display so both flip together.
  always_comb begin
    digSel = disp_d[4*idx_d +: 4];
    seg_d  = blank[idx_d] ? 7'b1111111 : segEncode(digSel);
    an_d   = ~(DIGITS'(1) << idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      seg_q   <= 7'b0000001;
      an_q    <= ~DIGITS'(1);
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign ready = (state_q == DONE);
  assign seg   = seg_q;
  assign an    = an_q;

endmodule

// File: tb/tb_bin_sevenseg_scan.sv
// Directed self-checking bench for bin_sevenseg_scan at WIDTH=8, DIGITS=3, SCAN_DIV=4.
// Expected leading-digit patterns follow SEVSEG_LZ_BLANK_EN when the bench is built with it.
module tb_bin_sevenseg_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] value;
  logic       busy;
  logic       ready;
  logic [6:0] seg;
  logic [2:0] an;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] SEG0 = 7'b0000001;
  localparam logic [6:0] SEG1 = 7'b1001111;
  localparam logic [6:0] SEG2 = 7'b0010010;
  localparam logic [6:0] SEG5 = 7'b0100100;
  localparam logic [6:0] SEG7 = 7'b0001111;
  localparam logic [6:0] SEG8 = 7'b0000000;
  localparam logic [6:0] SEG9 = 7'b0001100;
`ifdef SEVSEG_LZ_BLANK_EN
  localparam logic [6:0] ZLEAD = 7'b1111111;
`else
  localparam logic [6:0] ZLEAD = 7'b0000001;
`endif

  bin_sevenseg_scan #(
    .WIDTH   (8),
    .DIGITS  (3),
    .SCAN_DIV(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .value(value),
    .busy (busy),
    .ready(ready),
    .seg  (seg),
    .an   (an)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic l, input logic [7:0] v);
    load  = l;
    value = v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Wait (bounded) until digit k is selected, then check its segments.
  task automatic checkDigit(input int k, input logic [6:0] expSeg, input string tag);
    logic [2:0] want;
    want = ~(3'b001 << k);
    for (int i = 0; i < 16 && an !== want; i++) tick();
    checkOutput({tag, "_an"}, {29'd0, an}, {29'd0, want});
    checkOutput(tag, {25'd0, seg}, {25'd0, expSeg});
  endtask

  task automatic waitReady(input string tag);
    for (int i = 0; i < 30 && ready !== 1'b1; i++) tick();
    checkOutput(tag, {31'd0, ready}, 32'd1);
  endtask

  task automatic runConversion(input logic [7:0] v, input string tag);
    applyStimulus(1'b1, v);
    tick();
    applyStimulus(1'b0, 8'd0);
    waitReady(tag);
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int readyCount;
    int pulseT[$];
    logic [6:0] heldSeg;

    rst = 1'b1;
    applyStimulus(1'b0, 8'd0);
    tick();
    tick();
    checkOutput("rstBusy",  {31'd0, busy},  32'd0);
    checkOutput("rstReady", {31'd0, ready}, 32'd0);
    checkOutput("rstAn",    {29'd0, an},    32'b110);
    checkOutput("rstSeg",   {25'd0, seg},   {25'd0, SEG0});

    rst = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      logic [2:0] expAn;
      logic [6:0] expSeg;
      tick();
      if (t < 4)       begin expAn = 3'b110; expSeg = SEG0;  end
      else if (t < 8)  begin expAn = 3'b101; expSeg = ZLEAD; end
      else if (t < 12) begin expAn = 3'b011; expSeg = ZLEAD; end
      else             begin expAn = 3'b110; expSeg = SEG0;  end
      checkOutput($sformatf("scanAn_t%0d", t),  {29'd0, an},  {29'd0, expAn});
      checkOutput($sformatf("scanSeg_t%0d", t), {25'd0, seg}, {25'd0, expSeg});
    end

    $display("[TB] convert 255 with cycle-exact busy/ready");
    applyStimulus(1'b1, 8'd255);
    tick();
    applyStimulus(1'b0, 8'd0);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("busy255_k%0d", k),  {31'd0, busy},  (k <= 8) ? 32'd1 : 32'd0);
      checkOutput($sformatf("ready255_k%0d", k), {31'd0, ready}, (k == 8) ? 32'd1 : 32'd0);
      tick();
    end
    checkDigit(0, SEG5, "d0_255");
    checkDigit(1, SEG5, "d1_255");
    checkDigit(2, SEG2, "d2_255");

    $display("[TB] convert 7");
    runConversion(8'd7, "ready7");
    checkDigit(0, SEG7,  "d0_7");
    checkDigit(1, ZLEAD, "d1_7");
    checkDigit(2, ZLEAD, "d2_7");

    $display("[TB] load 100 then ignored load 42");
    applyStimulus(1'b1, 8'd100);
    tick();
    applyStimulus(1'b0, 8'd0);
    tick();
    tick();
    tick();
    applyStimulus(1'b1, 8'd42);
    tick();
    applyStimulus(1'b0, 8'd0);
    waitReady("ready100");
    tick();
    tick();
    checkOutput("idleAfter100", {31'd0, busy}, 32'd0);
    checkDigit(0, SEG0, "d0_100");
    checkDigit(1, SEG0, "d1_100");
    checkDigit(2, SEG1, "d2_100");

    $display("[TB] reset during conversion");
    runConversion(8'd255, "ready255b");
    applyStimulus(1'b1, 8'd9);
    tick();
    applyStimulus(1'b0, 8'd0);
    tick();
    tick();
    tick();
    heldSeg = (an === 3'b011) ? SEG2 : SEG5;
    checkOutput("heldDisplay", {25'd0, seg}, {25'd0, heldSeg});
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncRstBusy", {31'd0, busy}, 32'd0);
    checkOutput("asyncRstAn",   {29'd0, an},   32'b110);
    checkOutput("asyncRstSeg",  {25'd0, seg},  {25'd0, SEG0});
    tick();
    rst = 1'b0;
    readyCount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ready === 1'b1) readyCount++;
    end
    checkOutput("noReadyAfterRst", readyCount, 32'd0);
    checkDigit(0, SEG0,  "d0_afterRst");
    checkDigit(2, ZLEAD, "d2_afterRst");

    applyStimulus(1'b1, 8'd9);
    tick();
    applyStimulus(1'b0, 8'd0);
    repeat (7) tick();
    checkOutput("ready9Early", {31'd0, ready}, 32'd0);
    tick();
    checkOutput("ready9At9", {31'd0, ready}, 32'd1);
    tick();
    checkDigit(0, SEG9,  "d0_9");
    checkDigit(2, ZLEAD, "d2_9");

    $display("[TB] load held high with 128");
    applyStimulus(1'b1, 8'd128);
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (ready === 1'b1) pulseT.push_back(t);
    end
    applyStimulus(1'b0, 8'd0);
    checkOutput("heldPulseCount", pulseT.size(), 32'd3);
    if (pulseT.size() == 3) begin
      checkOutput("heldFirstPulse", pulseT[0], 32'd9);
      checkOutput("heldGap1", pulseT[1] - pulseT[0], 32'd10);
      checkOutput("heldGap2", pulseT[2] - pulseT[1], 32'd10);
    end
    tick();
    checkOutput("heldIdle", {31'd0, busy}, 32'd0);
    checkDigit(0, SEG8, "d0_128");
    checkDigit(1, SEG2, "d1_128");
    checkDigit(2, SEG1, "d2_128");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_sevenseg_scan.md
BIN_SEVENSEG_SCAN -- requirements
Module: bin_sevenseg_scan

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the unsigned binary input width.
REQ-002 The module SHALL have parameter DIGITS, default 3, meaning the decimal digit count; elaboration SHALL fail unless 10^DIGITS >= 2^WIDTH.
REQ-003 The module SHALL have parameter SCAN_DIV, default 4, meaning clocks per digit scan slot; valid values are 1 and above.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port load, input, 1 bit: conversion request, sampled on the clk rising edge.
REQ-007 The module SHALL have port value, input, WIDTH bits: unsigned binary operand, sampled when load is accepted.
REQ-008 The module SHALL have port busy, output, 1 bit: conversion in progress.
REQ-009 The module SHALL have port ready, output, 1 bit: one-cycle pulse when a new result is displayed.
REQ-010 The module SHALL have port seg, output, 7 bits: active-low segments {a,b,c,d,e,f,g}, with a as the MSB.
REQ-011 The module SHALL have port an, output, DIGITS bits: active-low digit enables; bit 0 is the least significant digit.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE; after reset it SHALL be in IDLE.
REQ-013 In IDLE with load=1, the block SHALL capture value, clear the BCD work register and enter SHIFT.
REQ-014 SHIFT SHALL run a sequential double-dabble conversion (add 3 to any BCD nibble >= 5, then shift left one bit) for exactly WIDTH cycles, then enter DONE.
REQ-015 DONE SHALL copy the work register to the display register, assert ready for that cycle only, and return to IDLE.
REQ-016 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE; with load accepted at edge N, ready SHALL be high in cycle N+WIDTH+1.
REQ-017 load while busy=1 SHALL be ignored, with no queuing; load asserted in the same cycle ready is high SHALL also be ignored.
REQ-018 The display register SHALL hold the previous result throughout a conversion; the display SHALL never show intermediate values.
REQ-019 The scan divider SHALL count 0 to SCAN_DIV-1; on wrap, the digit index SHALL advance 0, 1, ..., DIGITS-1, then back to 0.
REQ-020 an SHALL be all ones except bit [index], which SHALL be 0; scanning SHALL run continuously, independent of busy.
REQ-021 seg SHALL be the registered encoding of display digit [index]:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100
- blank=1111111
REQ-022 seg and an SHALL change on the same clock edge, with no cross-digit glitch.

Reset
REQ-023 While rst=1, the outputs SHALL hold these values: state=IDLE, busy=0, ready=0, work and display registers=0, divider=0, index=0, an = all ones except bit0=0, seg=0000001.
REQ-024 rst asserted mid-conversion SHALL abort the conversion; the display register SHALL return to 0 and no ready pulse SHALL follow.
REQ-025 rst SHALL act asynchronously on assertion; the first load SHALL be accepted on the first rising edge after deassertion.

Configuration
REQ-026 When macro SEVSEG_LZ_BLANK_EN is defined, any digit k>0 SHALL display blank if it and all digits above it are 0; digit 0 SHALL never be blanked.
REQ-027 When SEVSEG_LZ_BLANK_EN is undefined, all digits SHALL display their numeric value, including leading zeros.

Verification (WIDTH=8, DIGITS=3, SCAN_DIV=4)
REQ-028 Release reset with no load -> an cycles 110, 101, 011, 110, changing every 4 clocks; seg=0000001 on every digit (0000001 on digit0 and 1111111 on digits 1-2 with LZB).
REQ-029 load=1, value=255 -> busy for 9 cycles, ready at N+9; digits 2,1,0 = 0010010, 0100100, 0100100.
REQ-030 value=7 -> digit0=0001111; digits 1-2 = 1111111 with LZB, 0000001 without.
REQ-031 load 100, then load 42 three cycles later -> second load ignored; display shows 1,0,0 (0000001 on the zero digits, no blanking since digit 2 is non-zero).
REQ-032 Display shows 255; load 9, assert rst at cycle 4 of SHIFT -> no ready pulse; display 0; next load 9 -> ready at N+9; digit0=0001100.
REQ-033 load held high continuously with value=128 -> accepted once every 10 cycles; ready pulses spaced 10 cycles apart; display 1,2,8.
